// File: rtl/seq_mult_ctrl_if.sv
// Handshake and datapath-strobe bundle between a shift-add multiplier
// controller and its surroundings.
//
// Signals
//   start   begin a multiplication (sampled only while idle)
//   abort   synchronous cancel of a run in progress
//   b_lsb   current LSB of multiplier register B, fed back from the datapath
//   ld_a    load multiplicand register A from the operand bus
//   ld_b    load multiplier register B from the operand bus
//   clr_p   synchronous clear of product/accumulator register P
//   add_en  P <= P + A this cycle
//   shift   shift {P,B} right one bit this cycle
//   busy    multiplication in progress
//   done    one-cycle pulse, product valid in {P,B}
//   iter    current iteration index, 0..N-1
//
// Modports
//   master  side that issues start/abort and owns the datapath (drives b_lsb)
//   slave   the controller itself
interface seq_mult_ctrl_if #(
    parameter int N = 4
);
    localparam int CW = $clog2(N);

    logic          start;
    logic          abort;
    logic          b_lsb;
    logic          ld_a;
    logic          ld_b;
    logic          clr_p;
    logic          add_en;
    logic          shift;
    logic          busy;
    logic          done;
    logic [CW-1:0] iter;

    modport master (
        output start,
        output abort,
        output b_lsb,
        input  ld_a,
        input  ld_b,
        input  clr_p,
        input  add_en,
        input  shift,
        input  busy,
        input  done,
        input  iter
    );

    modport slave (
        input  start,
        input  abort,
        input  b_lsb,
        output ld_a,
        output ld_b,
        output clr_p,
        output add_en,
        output shift,
        output busy,
        output done,
        output iter
    );
endinterface

// File: rtl/seq_mult_ctrl.sv
// Control FSM for a shift-add sequential multiplier datapath.
// Accepts a start request, strobes the A/B/P registers through one load
// cycle followed by N add/shift pairs, then pulses done. The controller holds
// no arithmetic; the only datapath feedback is B[0] (bus.b_lsb).
//
// Ports
//   clk    rising-edge clock
//   clr_n  asynchronous active-low reset
//   bus    seq_mult_ctrl_if.slave: start/abort/b_lsb in, strobes/status out
//
// Parameters
//   N      operand width = iteration count, N >= 2
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start (abort blocks start)
// LOAD  | load A and B, clear P, rewind iteration counter
// ADD   | accumulate A into P when the current multiplier bit is 1
// SHIFT | shift {P,B} right; last iteration goes to DONE, else to ADD
// DONE  | one-cycle done pulse, product valid in {P,B}
//
// Latency: start sampled at edge k gives LOAD in k+1 and DONE in k+2N+2.
module seq_mult_ctrl #(
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           clr_n,
    seq_mult_ctrl_if.slave bus
);
    localparam int             CW   = $clog2(N);
    localparam logic [CW-1:0]  LAST = CW'(N - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        ADD   = 3'd2,
        SHIFT = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] iter_q;
    logic          last_iter;

    assign last_iter = (iter_q == LAST);

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // abort wins over every other transition; in IDLE it only has to
    // suppress start, which the IDLE branch handles directly.
    always_comb begin
        state_nxt = state;
        if (abort_active()) begin
            state_nxt = IDLE;
        end else begin
            unique case (state)
                IDLE:    if (bus.start && !bus.abort) state_nxt = LOAD;
                LOAD:    state_nxt = ADD;
                ADD:     state_nxt = SHIFT;
                SHIFT:   state_nxt = last_iter ? DONE : ADD;
                DONE:    state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    function automatic logic abort_active();
        return bus.abort && (state != IDLE);
    endfunction

    // The counter rewinds in LOAD and on abort; on normal completion it
    // stays at N-1 through DONE and IDLE until the next LOAD. It advances
    // only on non-final SHIFTs, so it can never pass N-1 or wrap.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            iter_q <= '0;
        end else if (abort_active()) begin
            iter_q <= '0;
        end else if (state == LOAD) begin
            iter_q <= '0;
        end else if (state == SHIFT && !last_iter) begin
            iter_q <= iter_q + CW'(1);
        end
    end

    // Strobes depend on the state register only, except add_en which
    // also qualifies on the live multiplier LSB. During an abort cycle the
    // strobes still follow the current state.
    always_comb begin
        bus.ld_a   = 1'b0;
        bus.ld_b   = 1'b0;
        bus.clr_p  = 1'b0;
        bus.add_en = 1'b0;
        bus.shift  = 1'b0;
        bus.busy   = 1'b0;
        bus.done   = 1'b0;
        unique case (state)
            IDLE: ;
            LOAD: begin
                bus.ld_a  = 1'b1;
                bus.ld_b  = 1'b1;
                bus.clr_p = 1'b1;
                bus.busy  = 1'b1;
            end
            ADD: begin
                bus.add_en = bus.b_lsb;
                bus.busy   = 1'b1;
            end
            SHIFT: begin
                bus.shift = 1'b1;
                bus.busy  = 1'b1;
            end
            DONE: begin
                bus.done = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.iter = iter_q;

    a_group_excl: assert property (@(posedge clk) disable iff (!clr_n)
        $onehot0({bus.ld_a | bus.ld_b | bus.clr_p, bus.add_en, bus.shift}));

    a_iter_bound: assert property (@(posedge clk) disable iff (!clr_n)
        iter_q <= LAST);

    a_done_not_busy: assert property (@(posedge clk) disable iff (!clr_n)
        !(bus.done && bus.busy));
endmodule

// File: tb/tb_seq_mult_ctrl.sv
module tb_seq_mult_ctrl;
    localparam int N   = 4;
    localparam int CW  = $clog2(N);
    localparam int LAT = 2 * N + 2;

    logic clk = 1'b0;
    logic clr_n;
    always #5 clk = ~clk;

    seq_mult_ctrl_if #(.N(N)) bus ();
    seq_mult_ctrl #(.N(N)) dut (.clk(clk), .clr_n(clr_n), .bus(bus));

    // Datapath model: A, B, P registers driven by the controller strobes.
    logic [N-1:0] op_a = '0, op_b = '0;
    logic [N-1:0] dp_a = '0, dp_b = '0;
    logic [N:0]   dp_p = '0;
    logic         use_dp = 1'b0;
    logic         b_tab = 1'b0;

    assign bus.b_lsb = use_dp ? dp_b[0] : b_tab;

    always @(posedge clk) begin
        if (bus.ld_a) dp_a <= op_a;
        if (bus.clr_p)       dp_p <= '0;
        else if (bus.add_en) dp_p <= dp_p + {1'b0, dp_a};
        else if (bus.shift)  dp_p <= dp_p >> 1;
        if (bus.ld_b)        dp_b <= op_b;
        else if (bus.shift)  dp_b <= {dp_p[0], dp_b[N-1:1]};
    end

    int n_cmp = 0;
    int n_bad = 0;
    int idle_iter = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // {ld_a, ld_b, clr_p, add_en, shift, busy, done, iter}
    function automatic logic [6+CW:0] outs();
        return {bus.ld_a, bus.ld_b, bus.clr_p, bus.add_en, bus.shift,
                bus.busy, bus.done, bus.iter};
    endfunction

    // Expected outputs at cycle offset off after the start cycle (off=0),
    // for multiplier operand b: LOAD, then N (ADD,SHIFT) pairs, then DONE.
    function automatic logic [6+CW:0] exp_at(input int off, input logic [N-1:0] b);
        logic [6:0]    s;
        logic [CW-1:0] it;
        if (off == 0) begin
            s = 7'b0000000; it = CW'(idle_iter);
        end else if (off == 1) begin
            s = 7'b1110010; it = CW'(idle_iter);
        end else if (off == LAT) begin
            s = 7'b0000001; it = CW'(N - 1);
        end else if (off % 2 == 0) begin
            s = {3'b000, b[(off - 2) / 2], 3'b010}; it = CW'((off - 2) / 2);
        end else begin
            s = 7'b0000110; it = CW'((off - 3) / 2);
        end
        return {s, it};
    endfunction

    function automatic logic [6+CW:0] idle_vec();
        return {7'b0000000, CW'(idle_iter)};
    endfunction

    // One transaction from IDLE: start pulse, per-cycle output check,
    // product check at done, optional abort at offset abort_at (1..LAT),
    // then one IDLE cycle check.
    task automatic run_txn(input logic [N-1:0] a, input logic [N-1:0] b,
                           input int abort_at, input string tag);
        int last;
        use_dp = 1'b1;
        op_a = a;
        op_b = b;
        last = (abort_at > 0) ? abort_at : LAT;
        for (int off = 0; off <= last; off++) begin
            bus.start = (off == 0);
            bus.abort = (off == abort_at);
            @(negedge clk);
            chk($sformatf("%s_off%0d", tag, off), outs(), exp_at(off, b));
            if (off == LAT)
                chk($sformatf("%s_prod", tag), {dp_p, dp_b}, int'(a) * int'(b));
            @(posedge clk); #1;
        end
        bus.start = 1'b0;
        bus.abort = 1'b0;
        idle_iter = (abort_at > 0) ? 0 : N - 1;
        @(negedge clk);
        chk($sformatf("%s_idle", tag), outs(), idle_vec());
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic       start;
        logic       abort;
        logic       b;
        logic [6:0] s;     // ld_a ld_b clr_p add_en shift busy done
        int         it;
    } vec_t;

    vec_t tab[12];

    initial begin
        // B = 4'b1011 presented LSB first on b_lsb in the ADD cycles.
        tab[0]  = '{1'b1, 1'b0, 1'b0, 7'b0000000, 0};
        tab[1]  = '{1'b0, 1'b0, 1'b0, 7'b1110010, 0};
        tab[2]  = '{1'b0, 1'b0, 1'b1, 7'b0001010, 0};
        tab[3]  = '{1'b0, 1'b0, 1'b0, 7'b0000110, 0};
        tab[4]  = '{1'b0, 1'b0, 1'b1, 7'b0001010, 1};
        tab[5]  = '{1'b0, 1'b0, 1'b0, 7'b0000110, 1};
        tab[6]  = '{1'b0, 1'b0, 1'b0, 7'b0000010, 2};
        tab[7]  = '{1'b0, 1'b0, 1'b0, 7'b0000110, 2};
        tab[8]  = '{1'b0, 1'b0, 1'b1, 7'b0001010, 3};
        tab[9]  = '{1'b0, 1'b0, 1'b0, 7'b0000110, 3};
        tab[10] = '{1'b0, 1'b0, 1'b0, 7'b0000001, 3};
        tab[11] = '{1'b0, 1'b0, 1'b0, 7'b0000000, 3};

        bus.start = 1'b0;
        bus.abort = 1'b0;
        clr_n = 1'b0;
        #12;
        chk("reset_outs", outs(), '0);
        @(negedge clk);
        clr_n = 1'b1;
        @(posedge clk); #1;

        // Table: 4'b1011 via b_lsb, start at cycle 0, done at cycle 10.
        use_dp = 1'b0;
        for (int i = 0; i < 12; i++) begin
            bus.start = tab[i].start;
            bus.abort = tab[i].abort;
            b_tab     = tab[i].b;
            @(negedge clk);
            chk($sformatf("tab%0d", i), outs(), {tab[i].s, CW'(tab[i].it)});
            @(posedge clk); #1;
        end
        bus.start = 1'b0;
        idle_iter = N - 1;

        // Full runs through the datapath model.
        run_txn(4'd13, 4'd11, -1, "m13x11");
        run_txn(4'd9,  4'b0000, -1, "b0000");
        run_txn(4'd7,  4'b1111, -1, "b1111");

        // Async reset during the iter=1 SHIFT cycle.
        use_dp = 1'b1;
        op_a = 4'd5;
        op_b = 4'd9;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_pre_shift", outs(), {7'b0000110, CW'(1)});
        #2;
        clr_n = 1'b0;
        #1;
        chk("rst_async_outs", outs(), '0);
        @(posedge clk);
        @(negedge clk);
        chk("rst_held_outs", outs(), '0);
        clr_n = 1'b1;
        idle_iter = 0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_release_idle", outs(), idle_vec());
        @(posedge clk); #1;

        // start held high: 11-cycle period, done at cycles 10 and 21.
        bus.start = 1'b1;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            chk($sformatf("held_done_c%0d", c), bus.done, (c % 11 == 10));
            chk($sformatf("held_busy_c%0d", c), bus.busy, (c % 11 >= 1 && c % 11 <= 9));
            @(posedge clk); #1;
        end
        bus.start = 1'b0;
        bus.abort = 1'b1;
        @(posedge clk); #1;
        bus.abort = 1'b0;
        idle_iter = 0;
        @(negedge clk);
        chk("held_abort_idle", outs(), idle_vec());
        @(posedge clk); #1;

        // abort in the iter=2 SHIFT (offset 7), then a fresh full run.
        run_txn(4'd6, 4'd14, 7, "abort_it2");
        @(negedge clk);
        chk("abort_gap_idle", outs(), idle_vec());
        @(posedge clk); #1;
        run_txn(4'd6, 4'd14, -1, "after_abort");

        // start and abort together in IDLE: stays IDLE.
        for (int c = 0; c < 3; c++) begin
            bus.start = 1'b1;
            bus.abort = 1'b1;
            @(negedge clk);
            chk($sformatf("start_abort_idle%0d", c), outs(), idle_vec());
            @(posedge clk); #1;
        end
        bus.start = 1'b0;
        bus.abort = 1'b0;
        @(negedge clk);
        chk("start_abort_after", outs(), idle_vec());
        @(posedge clk); #1;

        // Randomized transactions with optional abort and idle gaps.
        for (int t = 0; t < 40; t++) begin
            logic [N-1:0] ra, rb;
            int ab, gap;
            ra = N'($urandom);
            rb = N'($urandom);
            ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, LAT)) : -1;
            gap = int'($urandom_range(0, 3));
            run_txn(ra, rb, ab, $sformatf("rnd%0d", t));
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                chk($sformatf("rnd%0d_gap%0d", t, g), outs(), idle_vec());
                @(posedge clk); #1;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
